// File: rtl/csa_final_adder.sv
// ---------------------------------------------------------------------------
// csa_final_adder
//   Segmented, pipelined carry-propagate adder that resolves the carry-save
//   pair coming out of the Wallace-tree reduction into the final product.
//   Each of the NSTG = WIDTH/SEG stages adds one SEG-bit segment plus the
//   carry registered by the previous stage, so the critical path is a single
//   SEG-bit add. Valid/ready handshake on both sides; the whole pipe advances
//   or holds as one unit (bubbles are kept, not compressed).
//
// Parameters
//   WIDTH  operand/result width (must be a multiple of SEG, at least 2*SEG)
//   SEG    bits resolved per stage
//
// Ports
//   clock      rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   upstream presents a carry-save pair
//   in_ready   pair accepted this cycle (= !out_valid | out_ready)
//   in_sum     carry-save sum row
//   in_carry   carry-save carry row (already aligned)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   (in_sum + in_carry) mod 2^WIDTH
//   cout       carry out of bit WIDTH-1 (only with CSA_FINAL_ADDER_COUT_EN)
//
// Build option
//   CSA_FINAL_ADDER_COUT_EN  adds the registered cout output.
// ---------------------------------------------------------------------------

// One SEG-bit segment adder with carry in/out.
module csa_seg_add #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
endmodule

module csa_final_adder #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef CSA_FINAL_ADDER_COUT_EN
    output logic             cout,
`endif
    output logic [WIDTH-1:0] out_data
);
    localparam int NSTG = WIDTH / SEG;

    // Stage k valid bit; vld_pipe[NSTG-1] is the output stage.
    logic [NSTG-1:0] vld_pipe;
    logic            advance;

    assign out_valid = vld_pipe[NSTG-1];
    // Only depends on the output side, never on in_valid.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] s_i;      // sum row entering this stage
        logic [WIDTH-1:0] c_i;      // carry row entering this stage
        logic             ci;       // segment carry-in
        logic             v_i;      // valid entering this stage
        logic [SEG-1:0]   seg_sum;
        logic [WIDTH-1:0] s_nxt;
        logic [WIDTH-1:0] s_r;      // lower segments resolved, upper raw

        if (k == 0) begin : g_head
            assign s_i = in_sum;
            assign c_i = in_carry;
            assign ci  = 1'b0;
            assign v_i = in_valid;
        end else begin : g_tail
            assign s_i = g_stg[k-1].s_r;
            assign c_i = g_stg[k-1].g_fwd.c_r;
            assign ci  = g_stg[k-1].g_fwd.cy_r;
            assign v_i = vld_pipe[k-1];
        end

        // Resolved segment overwrites the raw sum-row segment in place.
        always_comb begin
            s_nxt                = s_i;
            s_nxt[k*SEG +: SEG]  = seg_sum;
        end

        // Bubbles load zeros so the pipe contents stay deterministic.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s_r         <= '0;
                vld_pipe[k] <= 1'b0;
            end else if (advance) begin
                s_r         <= v_i ? s_nxt : '0;
                vld_pipe[k] <= v_i;
            end
        end

        if (k < NSTG-1) begin : g_fwd
            logic [WIDTH-1:0] c_r;
            logic             cy_r;
            logic             co;

            csa_seg_add #(.SEG(SEG)) u_add (
                .a  (s_i[k*SEG +: SEG]),
                .b  (c_i[k*SEG +: SEG]),
                .ci (ci),
                .s  (seg_sum),
                .co (co)
            );

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    c_r  <= '0;
                    cy_r <= 1'b0;
                end else if (advance) begin
                    c_r  <= v_i ? c_i : '0;
                    cy_r <= v_i ? co  : 1'b0;
                end
            end
        end else begin : g_last
`ifdef CSA_FINAL_ADDER_COUT_EN
            logic cy_r;
            logic co;

            csa_seg_add #(.SEG(SEG)) u_add (
                .a  (s_i[k*SEG +: SEG]),
                .b  (c_i[k*SEG +: SEG]),
                .ci (ci),
                .s  (seg_sum),
                .co (co)
            );

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n)
                    cy_r <= 1'b0;
                else if (advance)
                    cy_r <= v_i ? co : 1'b0;
            end
`else
            // MSB carry is dropped: plain modulo-2^SEG segment add.
            assign seg_sum = s_i[k*SEG +: SEG] + c_i[k*SEG +: SEG]
                           + {{(SEG-1){1'b0}}, ci};
`endif
        end
    end

    assign out_data = g_stg[NSTG-1].s_r;
`ifdef CSA_FINAL_ADDER_COUT_EN
    assign cout     = g_stg[NSTG-1].g_last.cy_r;
`endif

endmodule

// File: tb/tb_csa_final_adder.sv
module tb_csa_final_adder;
    localparam int W = 64;

    logic          clock;
    logic          reset_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_sum;
    logic [W-1:0]  in_carry;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
`ifdef CSA_FINAL_ADDER_COUT_EN
    logic          cout;
`endif

    int checks = 0;
    int passes = 0;

    // Expected {cout, data} per accepted transfer, in order.
    logic [W:0] exp_q[$];

    csa_final_adder #(.WIDTH(64), .SEG(16)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef CSA_FINAL_ADDER_COUT_EN
        .cout      (cout),
`endif
        .out_data  (out_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Scoreboard: pop and compare on every completed output handshake.
    always @(negedge clock) begin
        logic [W:0] e;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL extra_output got=%h expected no output", out_data);
            end else begin
                e = exp_q.pop_front();
                if (out_data !== e[W-1:0])
                    $display("FAIL out_data got=%h expected=%h", out_data, e[W-1:0]);
                else
                    passes++;
`ifdef CSA_FINAL_ADDER_COUT_EN
                checks++;
                if (cout !== e[W])
                    $display("FAIL cout got=%b expected=%b", cout, e[W]);
                else
                    passes++;
`endif
            end
        end
    end

    task automatic drive(input logic [W-1:0] s, input logic [W-1:0] c);
        in_valid = 1'b1;
        in_sum   = s;
        in_carry = c;
        exp_q.push_back({1'b0, s} + {1'b0, c});
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_sum   = '0;
        in_carry = '0;
    endtask

    // Bounded wait for the scoreboard to empty.
    task automatic wait_empty();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clock);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sum    = 64'hDEAD_BEEF_0000_1111;
        in_carry  = 64'h1234;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b expected=0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL reset_out_data got=%h expected=0", out_data); else passes++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b expected=1", in_ready); else passes++;
`ifdef CSA_FINAL_ADDER_COUT_EN
        checks++; if (cout !== 1'b0) $display("FAIL reset_cout got=%b expected=0", cout); else passes++;
`endif
        idle();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_basic();
        int first;
        first = -1;
        out_ready = 1'b1;
        @(posedge clock); #1;
        drive(64'h1234, 64'h1);
        for (int j = 1; j <= 8; j++) begin
            @(posedge clock); #1;
            if (j == 1) idle();
            @(negedge clock);
            if (out_valid && first < 0) first = j;
        end
        // Accepted on edge 1, visible after edge 4.
        checks++; if (first !== 4) $display("FAIL basic_latency got=%0d expected=4", first); else passes++;
        wait_empty();
        checks++; if (exp_q.size() !== 0) $display("FAIL basic_drain got=%0d pending expected=0", exp_q.size()); else passes++;
    endtask

    task automatic test_ripple();
        logic [W-1:0] sv [4];
        logic [W-1:0] cv [4];
        sv[0] = 64'hFFFF_FFFF_FFFF_FFFF; cv[0] = 64'h1;
        sv[1] = 64'h0000_FFFF_FFFF_FFFF; cv[1] = 64'h1;
        sv[2] = 64'h0000_0000_FFFF_FFFF; cv[2] = 64'h1;
        sv[3] = 64'h8000_0000_0000_8000; cv[3] = 64'h8000_0000_0000_8000;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            drive(sv[i], cv[i]);
        end
        @(posedge clock); #1;
        idle();
        wait_empty();
        checks++; if (exp_q.size() !== 0) $display("FAIL ripple_drain got=%0d pending expected=0", exp_q.size()); else passes++;
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        out_ready = 1'b1;
        for (int it = 0; it < 16; it++) begin
            @(posedge clock); #1;
            if (it < 8) drive(64'(it + 1), 64'(it + 1) << 20);
            else idle();
            @(negedge clock);
            // Driven in iterations 0..7 -> valid in iterations 4..11.
            exp_v = (it >= 4) && (it < 12);
            checks++; if (out_valid !== exp_v) $display("FAIL b2b_valid it=%0d got=%b expected=%b", it, out_valid, exp_v); else passes++;
            checks++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready it=%0d got=%b expected=1", it, in_ready); else passes++;
        end
        wait_empty();
        checks++; if (exp_q.size() !== 0) $display("FAIL b2b_drain got=%0d pending expected=0", exp_q.size()); else passes++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        bit           seen;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            drive({$urandom, $urandom}, {$urandom, $urandom});
        end
        @(posedge clock); #1;
        idle();
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clock);
            seen = out_valid;
        end
        checks++; if (!seen) $display("FAIL bp_fill got=no_valid expected=out_valid"); else passes++;
        held = exp_q[0][W-1:0];
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%b expected=0", in_ready); else passes++;
            checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid got=%b expected=1", out_valid); else passes++;
            checks++; if (out_data !== held) $display("FAIL bp_hold got=%h expected=%h", out_data, held); else passes++;
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_empty();
        checks++; if (exp_q.size() !== 0) $display("FAIL bp_drain got=%0d pending expected=0", exp_q.size()); else passes++;
        checks++; if (out_valid !== 1'b0) $display("FAIL bp_no_dup got=%b expected=0", out_valid); else passes++;
    endtask

    task automatic test_reset_mid();
        bit seen;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            drive(64'(i + 100), 64'hFFFF_0000);
        end
        @(posedge clock); #1;
        idle();
        seen = 0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clock);
            seen = out_valid;
        end
        checks++; if (!seen) $display("FAIL rst_fill got=no_valid expected=out_valid"); else passes++;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got=%b expected=0", out_valid); else passes++;
        checks++; if (out_data !== '0) $display("FAIL rst_mid_data got=%h expected=0", out_data); else passes++;
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        #3;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            checks++; if (out_valid !== 1'b0) $display("FAIL rst_after_valid n=%0d got=%b expected=0", n, out_valid); else passes++;
        end
    endtask

    task automatic test_end_to_end();
        logic [31:0] a, b;
        logic [W-1:0] pp0, pp1;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        // Two partial products compressed by one half-adder row into carry-save form.
        pp0 = 64'(a) * 64'(b[15:0]);
        pp1 = (64'(a) * 64'(b[31:16])) << 16;
        out_ready = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b1;
        in_sum   = pp0 ^ pp1;
        in_carry = (pp0 & pp1) << 1;
        exp_q.push_back({1'b0, 64'hFFFF_FFFE_0000_0001});
        @(posedge clock); #1;
        idle();
        wait_empty();
        checks++; if (exp_q.size() !== 0) $display("FAIL e2e_drain got=%0d pending expected=0", exp_q.size()); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_end_to_end();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/csa_final_adder.md
Name: csa_final_adder

Overview:
- Pipelined carry-propagate adder directly downstream of the Wallace-tree reduction.
- Consumes the two 64-bit carry-save vectors (sum row and carry row) and produces the final 64-bit product.
- Replaces the single-cycle 64-bit add with a segmented, registered adder so that the critical path is one SEG-bit add.
- Uses valid/ready handshakes on both sides so that the multiplier can be stalled by its consumer.

Parameters:
- WIDTH, 64, operand and result width in bits.
- SEG, 16, bits added per pipeline stage. WIDTH must be an integer multiple of SEG. NSTG = WIDTH/SEG.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has a carry-save pair.
- in_ready  out  1  block accepts the pair this cycle.
- in_sum  in  WIDTH  carry-save sum row.
- in_carry  in  WIDTH  carry-save carry row, already aligned with no shift applied here.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  in_sum + in_carry, modulo 2^WIDTH.

Behaviour:
- Reset: reset_n low clears all NSTG stage valid bits, all data registers, out_valid and out_data to 0, and (with the macro) cout to 0. Assertion takes effect immediately; release is sampled at the clock edge.
- Any in-flight data at reset is discarded; no partial results are emitted after reset.
- Pipeline: NSTG register stages. Stage k (k = 0..NSTG-1):
  - adds bits [k*SEG +: SEG] of both operands plus the carry registered by stage k-1 (carry-in = 0 for stage 0);
  - registers the SEG-bit sum and the carry-out;
  - passes already-summed lower segments and not-yet-summed upper operand segments forward unchanged.
- Stage NSTG-1 drives out_data and out_valid.
- Latency: the transfer accepted at edge t appears with out_valid = 1 after edge t+NSTG-1. This is 4 cycles for the defaults, counting the accept edge as cycle 1.
- Advance rule: advance = !out_valid | out_ready; in_ready = advance.
  - When advance = 1, every stage loads from its predecessor, and stage 0 loads the input with valid = in_valid.
  - When advance = 0, all stages hold their contents, including bubbles.
- Transfer: a transfer occurs on an edge where in_valid & in_ready. Output handshake completes on out_valid & out_ready.
- Throughput: one result per cycle while out_ready = 1.
- Bubbles:
  - Invalid stages still shift; their data is don't-care, and is zeroed so results are deterministic.
  - Bubbles are not compressed.
- Simultaneous output pop and input push with a full pipeline: both occur in the same cycle, with no loss.
- out_data and out_valid remain stable while out_valid & !out_ready.
- in_ready is a combinational function of out_valid and out_ready only; it does not depend on in_valid.
- Arithmetic: unsigned modulo 2^WIDTH. The carry out of the MSB is dropped unless the optional feature is enabled.

Optional Feature:
- Macro: CSA_FINAL_ADDER_COUT_EN.
- Defined: adds output port cout (1 bit), equal to the carry out of bit WIDTH-1 for the same transaction. It is registered alongside out_data, cleared on reset, and held under stall.
- Undefined: no cout port; the MSB carry is discarded and no register is allocated for it.

Test Plan:
- Basic add: in_sum=0x0000_0000_0000_1234, in_carry=0x0000_0000_0000_0001, out_ready=1 -> out_data=0x0000_0000_0000_1235, out_valid exactly 4 cycles after the accept edge.
- Full ripple: in_sum=0xFFFF_FFFF_FFFF_FFFF, in_carry=0x0000_0000_0000_0001 -> out_data=0, cout=1 when the macro is on. in_sum=0x0000_FFFF_FFFF_FFFF, in_carry=1 -> out_data=0x0001_0000_0000_0000.
- Back-to-back: 8 consecutive pairs (i, i<<20) for i=1..8 with out_ready=1 -> 8 consecutive out_valid cycles with in-order results i + (i<<20), and in_ready constantly 1.
- Backpressure:
  - Fill with 4 transactions, then hold out_ready=0 for 5 cycles -> in_ready=0 while out_valid=1, and out_data is held.
  - Release -> results drain in order with no loss or duplication.
- Reset mid-operation: assert reset_n=0 asynchronously with 3 transactions in flight -> out_valid=0 and out_data=0 immediately. After release with no new input, out_valid stays 0 for 6 cycles.
- End-to-end: 32x32 operands 0xFFFF_FFFF x 0xFFFF_FFFF via the reduction tree -> out_data=0xFFFF_FFFE_0000_0001.
